// File: rtl/seq_detector_pkg.sv
// Shared types and constants for the serial 1011 pattern detector.
package seq_det_pkg;

    // FSM state encoding; values 5-7 are unused and recover to S_IDLE.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_1    = 3'd1,
        S_10   = 3'd2,
        S_101  = 3'd3,
        S_1011 = 3'd4
    } det_state_t;

    // The pattern being searched for, first received bit in the MSB.
    localparam logic [3:0] PATTERN     = 4'b1011;
    localparam int         PATTERN_LEN = 4;

endpackage

// File: rtl/seq_detector_if.sv
// Data, control and status signals of the pattern detector, bundled so the
// upstream driver and the LED/bench side see one port.
interface seq_detector_if #(
    parameter int COUNT_W = 8
);
    logic               en;
    logic               din;
    logic               clr;
    logic               match;
    logic [COUNT_W-1:0] match_count;
    logic               overflow;
    logic [2:0]         state_dbg;

    modport master (
        output en, din, clr,
        input  match, match_count, overflow, state_dbg
    );

    modport slave (
        input  en, din, clr,
        output match, match_count, overflow, state_dbg
    );
endinterface

// File: rtl/seq_detector_sat_counter.sv
// Saturating event counter with a sticky overflow flag; clr beats inc.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         overflow
);

    // Count events, hold at all-ones and remember that one was lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            count    <= '0;
            overflow <= 1'b0;
        end else if (clr) begin
            count    <= '0;
            overflow <= 1'b0;
        end else if (inc) begin
            if (&count) begin
                overflow <= 1'b1;
            end else begin
                count <= count + W'(1);
            end
        end
    end

endmodule

// File: rtl/seq_detector.sv
// Moore FSM that finds 1011 in an en-qualified serial stream, pulses match
// one clock after the final bit, and counts detections.
module seq_detector
    import seq_det_pkg::*;
#(
    parameter int COUNT_W = 8,
    parameter bit OVERLAP = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    seq_detector_if.slave       bus
);

    det_state_t state;
    det_state_t nxt;
    logic       hit;
    logic       advance;
    logic       match_q;

    // Transition table; unused encodings fall back to S_IDLE.
    function automatic det_state_t next_state(input det_state_t s, input logic d);
        case (s)
            S_IDLE:  return d ? S_1    : S_IDLE;
            S_1:     return d ? S_1    : S_10;
            S_10:    return d ? S_101  : S_IDLE;
            S_101:   return d ? S_1011 : S_10;
            S_1011:  return d ? S_1    : (OVERLAP ? S_10 : S_IDLE);
            default: return S_IDLE;
        endcase
    endfunction

    // A detection is the valid bit that moves the FSM into S_1011; illegal
    // states always move on so they recover even while en is low.
    always_comb begin
        nxt     = next_state(state, bus.din);
        hit     = bus.en && (nxt == S_1011);
        advance = bus.en || (state > S_1011);
    end

    // State register and the registered match pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            match_q <= 1'b0;
        end else begin
            match_q <= hit;
            if (advance) begin
                state <= nxt;
            end
        end
    end

    sat_counter #(
        .W (COUNT_W)
    ) u_count (
        .clk      (clk),
        .reset    (reset),
        .inc      (hit),
        .clr      (bus.clr),
        .count    (bus.match_count),
        .overflow (bus.overflow)
    );

    assign bus.match     = match_q;
    assign bus.state_dbg = state;

endmodule

// File: tb/tb_seq_detector.sv
// Scoreboard bench for seq_detector: three instances (overlap, non-overlap,
// 2-bit counter) driven by directed bit streams.
module tb_seq_detector;
    import seq_det_pkg::*;

    typedef struct {
        int    cnt;
        bit    ovf;
        string tag;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    exp_t qA[$];
    exp_t qB[$];
    exp_t qC[$];
    exp_t popA;
    exp_t popB;
    exp_t popC;

    seq_detector_if #(.COUNT_W(8)) ifA ();
    seq_detector_if #(.COUNT_W(8)) ifB ();
    seq_detector_if #(.COUNT_W(2)) ifC ();

    seq_detector #(.COUNT_W(8), .OVERLAP(1'b1)) dutA (.clk(clk), .reset(reset), .bus(ifA.slave));
    seq_detector #(.COUNT_W(8), .OVERLAP(1'b0)) dutB (.clk(clk), .reset(reset), .bus(ifB.slave));
    seq_detector #(.COUNT_W(2), .OVERLAP(1'b1)) dutC (.clk(clk), .reset(reset), .bus(ifC.slave));

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Drive one clock of input on the selected unit and queue the match
    // the hand-worked table predicts for it.
    task automatic applyStimulus(input int unit, input logic e, input logic d, input logic c,
                                 input bit expMatch, input int expCnt, input bit expOvf,
                                 input string tag);
        exp_t x;
        x.cnt = expCnt;
        x.ovf = expOvf;
        x.tag = tag;
        case (unit)
            0: begin ifA.en = e; ifA.din = d; ifA.clr = c; if (expMatch) qA.push_back(x); end
            1: begin ifB.en = e; ifB.din = d; ifB.clr = c; if (expMatch) qB.push_back(x); end
            default: begin ifC.en = e; ifC.din = d; ifC.clr = c; if (expMatch) qC.push_back(x); end
        endcase
        tick();
        case (unit)
            0: begin ifA.en = 1'b0; ifA.clr = 1'b0; end
            1: begin ifB.en = 1'b0; ifB.clr = 1'b0; end
            default: begin ifC.en = 1'b0; ifC.clr = 1'b0; end
        endcase
    endtask

    // Monitor for unit A: every match pulse must correspond to a queued entry.
    always @(negedge clk) begin
        if (ifA.match === 1'b1) begin
            if (qA.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_match_A actual=1 expected=0 t=%0t", $time);
            end else begin
                popA = qA.pop_front();
                checkOutput({popA.tag, "_cnt"}, int'(ifA.match_count), popA.cnt);
                checkOutput({popA.tag, "_ovf"}, int'(ifA.overflow), int'(popA.ovf));
            end
        end
    end

    // Monitor for unit B.
    always @(negedge clk) begin
        if (ifB.match === 1'b1) begin
            if (qB.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_match_B actual=1 expected=0 t=%0t", $time);
            end else begin
                popB = qB.pop_front();
                checkOutput({popB.tag, "_cnt"}, int'(ifB.match_count), popB.cnt);
                checkOutput({popB.tag, "_ovf"}, int'(ifB.overflow), int'(popB.ovf));
            end
        end
    end

    // Monitor for unit C.
    always @(negedge clk) begin
        if (ifC.match === 1'b1) begin
            if (qC.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_match_C actual=1 expected=0 t=%0t", $time);
            end else begin
                popC = qC.pop_front();
                checkOutput({popC.tag, "_cnt"}, int'(ifC.match_count), popC.cnt);
                checkOutput({popC.tag, "_ovf"}, int'(ifC.overflow), int'(popC.ovf));
            end
        end
    end

    // Directed test sequence.
    initial begin
        logic [6:0]  stream7;
        logic [6:0]  expOvl;
        logic [6:0]  expNon;
        logic [15:0] satStream;
        logic [3:0]  pat;
        int          k;

        checks   = 0;
        failures = 0;
        clk      = 1'b0;
        reset    = 1'b1;
        ifA.en = 1'b0; ifA.din = 1'b0; ifA.clr = 1'b0;
        ifB.en = 1'b0; ifB.din = 1'b0; ifB.clr = 1'b0;
        ifC.en = 1'b0; ifC.din = 1'b0; ifC.clr = 1'b0;
        tick();
        tick();
        checkOutput("rst_state", int'(ifA.state_dbg), 0);
        checkOutput("rst_match", int'(ifA.match), 0);
        checkOutput("rst_count", int'(ifA.match_count), 0);
        checkOutput("rst_ovf", int'(ifA.overflow), 0);
        reset = 1'b0;
        tick();

        // Overlapping detection: 1,0,1,1,0,1,1 -> matches after bits 4 and 7.
        stream7 = 7'b1011011;
        expOvl  = 7'b0001001;
        expNon  = 7'b0001000;
        for (int i = 0; i < 7; i++) begin
            applyStimulus(0, 1'b1, stream7[6-i], 1'b0, expOvl[6-i], (i < 4) ? 1 : 2, 1'b0, "ovl");
        end
        checkOutput("ovl_state", int'(ifA.state_dbg), 4);
        checkOutput("ovl_count", int'(ifA.match_count), 2);
        tick();
        checkOutput("ovl_hold_state", int'(ifA.state_dbg), 4);

        // Non-overlapping detection on the same stream.
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1, 1'b1, stream7[6-i], 1'b0, expNon[6-i], 1, 1'b0, "non");
        end
        checkOutput("non_state", int'(ifB.state_dbg), 1);
        checkOutput("non_count", int'(ifB.match_count), 1);
        tick();

        reset = 1'b1;
        tick();
        reset = 1'b0;

        // en gating: invalid cycles carry the opposite bit and must be ignored.
        pat = PATTERN;
        for (int i = 0; i < PATTERN_LEN; i++) begin
            applyStimulus(0, 1'b1, pat[3-i], 1'b0, (i == 3), 1, 1'b0, "gate");
            k = int'(ifA.state_dbg);
            applyStimulus(0, 1'b0, ~pat[3-i], 1'b0, 1'b0, 0, 1'b0, "gate_idle");
            checkOutput($sformatf("gate_hold_%0d", i), int'(ifA.state_dbg), (i == 0) ? 1 : (i == 1) ? 2 : (i == 2) ? 3 : 4);
            checkOutput($sformatf("gate_stable_%0d", i), int'(ifA.state_dbg), k);
        end

        // Saturation on a 2-bit counter, then clr racing the fifth increment.
        satStream = 16'b1011_011_011_011_011;
        k = 0;
        for (int i = 0; i < 16; i++) begin
            if (i == 3 || i == 6 || i == 9 || i == 12 || i == 15) k++;
            applyStimulus(2, 1'b1, satStream[15-i], (i == 15),
                          (i == 3 || i == 6 || i == 9 || i == 12 || i == 15),
                          (k == 5) ? 0 : (k > 3) ? 3 : k, (k == 4), "sat");
            if (i == 9) begin
                checkOutput("sat3_count", int'(ifC.match_count), 3);
                checkOutput("sat3_ovf", int'(ifC.overflow), 0);
            end
            if (i == 12) begin
                checkOutput("sat4_count", int'(ifC.match_count), 3);
                checkOutput("sat4_ovf", int'(ifC.overflow), 1);
            end
        end
        checkOutput("clr_count", int'(ifC.match_count), 0);
        checkOutput("clr_ovf", int'(ifC.overflow), 0);
        checkOutput("clr_state", int'(ifC.state_dbg), 4);
        tick();

        // Reset mid-pattern wins over a completing bit.
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0, "mid");
        applyStimulus(0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, "mid");
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0, "mid");
        checkOutput("mid_pre_state", int'(ifA.state_dbg), 3);
        reset = 1'b1;
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0, "mid");
        reset = 1'b0;
        checkOutput("mid_rst_state", int'(ifA.state_dbg), 0);
        checkOutput("mid_rst_match", int'(ifA.match), 0);
        checkOutput("mid_rst_count", int'(ifA.match_count), 0);
        checkOutput("mid_rst_ovf", int'(ifA.overflow), 0);
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0, "mid");
        checkOutput("mid_after_state", int'(ifA.state_dbg), 1);

        // Illegal encoding recovers to S_IDLE even with en low.
        force dutA.state = det_state_t'(3'd6);
        #1;
        release dutA.state;
        checkOutput("illegal_forced", int'(ifA.state_dbg), 6);
        ifA.en = 1'b0;
        tick();
        checkOutput("illegal_state", int'(ifA.state_dbg), 0);
        checkOutput("illegal_match", int'(ifA.match), 0);
        tick();
        tick();

        checkOutput("pending_A", qA.size(), 0);
        checkOutput("pending_B", qB.size(), 0);
        checkOutput("pending_C", qC.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
